// File: rtl/timer_pkg.sv
// Register map, control-bit positions and channel address decode for timer_bank.
package timer_pkg;

  localparam logic [7:0] TIME_LO_OFS  = 8'h00;
  localparam logic [7:0] TIME_HI_OFS  = 8'h04;
  localparam logic [7:0] PRESCALE_OFS = 8'h08;
  localparam logic [7:0] CH_BASE      = 8'h10;
  localparam logic [7:0] CH_STRIDE    = 8'h10;

  // word offset inside a channel page (address bits [3:2])
  localparam logic [1:0] CTRL_OFS   = 2'd0;
  localparam logic [1:0] LOAD_OFS   = 2'd1;
  localparam logic [1:0] COUNT_OFS  = 2'd2;
  localparam logic [1:0] STATUS_OFS = 2'd3;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_PER = 1;
  localparam int CTRL_IE  = 2;

  typedef struct packed {
    logic ie;
    logic per;
    logic en;
  } ch_ctrl_t;

  // Channel pages are 16 bytes, so address bits [7:4] select the page.
  function automatic logic ch_hit(input logic [3:0] page, input int ch);
    return page == 4'((CH_BASE + 8'(ch) * CH_STRIDE) >> 4);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: CTRL/LOAD/COUNT/STATUS plus its interrupt request.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk_bus,
  input  logic        rst,
  input  logic        tick,
  input  logic        wr_ctrl,
  input  logic        wr_load,
  input  logic        wr_status,
  input  logic [31:0] wdata,
  output logic [31:0] ctrl_rd,
  output logic [31:0] load_rd,
  output logic [31:0] count_rd,
  output logic [31:0] status_rd,
  output logic        irq_ch
);

  ch_ctrl_t         ctrl_q, ctrl_d;
  logic [WIDTH-1:0] load_q, count_q, count_d;
  logic             exp_q, exp_d, expire;
  logic             unused_wdata;

  always_comb begin
    ctrl_d  = ctrl_q;
    count_d = count_q;
    expire  = 1'b0;
    if (wr_ctrl) begin
      // a CTRL write owns its edge: no decrement or expiry alongside it
      ctrl_d.en  = wdata[CTRL_EN];
      ctrl_d.per = wdata[CTRL_PER];
      ctrl_d.ie  = wdata[CTRL_IE];
      if (wdata[CTRL_EN] && !ctrl_q.en) count_d = load_q;
    end else if (tick && ctrl_q.en) begin
      if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        expire = 1'b1;
        if (ctrl_q.per) count_d = load_q;
        else            ctrl_d.en = 1'b0;
      end
    end
    exp_d = expire | (exp_q & ~(wr_status & wdata[0]));
  end

  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      ctrl_q  <= '0;
      load_q  <= '0;
      count_q <= '0;
      exp_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      exp_q   <= exp_d;
      if (wr_load) load_q <= wdata[WIDTH-1:0];
    end
  end

  assign ctrl_rd      = 32'(ctrl_q);
  assign load_rd      = 32'(load_q);
  assign count_rd     = 32'(count_q);
  assign status_rd    = {31'h0, exp_q};
  assign irq_ch       = exp_q & ctrl_q.ie;
  assign unused_wdata = ^wdata;

endmodule

// File: rtl/timer_bank.sv
// Bus-mapped timer: prescaled 64-bit TIME with latched high word, NUM_CH timer channels, shared irq.
module timer_bank
  import timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32,
  parameter int PRE_W  = 16
) (
  input  logic        clk_bus,
  input  logic        rst,
  input  logic [7:0]  bus_address,
  input  logic [31:0] bus_data_i,
  input  logic        bus_read,
  input  logic        bus_write,
  output logic [31:0] bus_data_o,
  output logic        irq
);

  logic [7:0]              addr_w;
  logic [PRE_W-1:0]        pre_q, pc_q;
  logic [63:0]             time_q;
  logic [31:0]             shadow_q;
  logic                    tick, wr_pre, rd_lo, irq_q;
  logic                    unused_addr;
  logic [NUM_CH-1:0]       ch_sel, wr_ctrl, wr_load, wr_status, irq_ch;
  logic [NUM_CH-1:0][31:0] ctrl_rd, load_rd, count_rd, status_rd;

  assign addr_w      = {bus_address[7:2], 2'b00};
  assign unused_addr = ^bus_address[1:0];
  assign tick        = (pc_q == pre_q);
  assign wr_pre      = bus_write && (addr_w == PRESCALE_OFS);
  assign rd_lo       = bus_read && (addr_w == TIME_LO_OFS);

  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      pre_q    <= '0;
      pc_q     <= '0;
      time_q   <= '0;
      shadow_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_pre) begin
        pre_q <= bus_data_i[PRE_W-1:0];
        pc_q  <= '0;
      end else if (tick) begin
        pc_q  <= '0;
      end else begin
        pc_q  <= pc_q + PRE_W'(1);
      end
      time_q <= time_q + 64'(tick);
      // high word frozen alongside the low-word read so the pair is coherent
      if (rd_lo) shadow_q <= time_q[63:32];
      irq_q <= |irq_ch;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_sel[i]    = ch_hit(addr_w[7:4], i);
    assign wr_ctrl[i]   = bus_write && ch_sel[i] && (addr_w[3:2] == CTRL_OFS);
    assign wr_load[i]   = bus_write && ch_sel[i] && (addr_w[3:2] == LOAD_OFS);
    assign wr_status[i] = bus_write && ch_sel[i] && (addr_w[3:2] == STATUS_OFS);

    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk_bus   (clk_bus),
      .rst       (rst),
      .tick      (tick),
      .wr_ctrl   (wr_ctrl[i]),
      .wr_load   (wr_load[i]),
      .wr_status (wr_status[i]),
      .wdata     (bus_data_i),
      .ctrl_rd   (ctrl_rd[i]),
      .load_rd   (load_rd[i]),
      .count_rd  (count_rd[i]),
      .status_rd (status_rd[i]),
      .irq_ch    (irq_ch[i])
    );
  end

  always_comb begin
    bus_data_o = '0;
    if (bus_read) begin
      case (addr_w)
        TIME_LO_OFS:  bus_data_o = time_q[31:0];
        TIME_HI_OFS:  bus_data_o = shadow_q;
        PRESCALE_OFS: bus_data_o = 32'(pre_q);
        default: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel[i]) begin
              case (addr_w[3:2])
                CTRL_OFS:  bus_data_o = ctrl_rd[i];
                LOAD_OFS:  bus_data_o = load_rd[i];
                COUNT_OFS: bus_data_o = count_rd[i];
                default:   bus_data_o = status_rd[i];
              endcase
            end
          end
        end
      endcase
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_timer_bank.sv
// Directed and randomized checks of timer_bank against a transaction-level reference model.
module tb_timer_bank;

  localparam int NCH = 4;

  logic        clk_bus = 1'b0;
  logic        rst;
  logic [7:0]  bus_address;
  logic [31:0] bus_data_i;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_data_o;
  logic        irq;

  always #5 clk_bus = ~clk_bus;

  timer_bank #(.NUM_CH(NCH), .WIDTH(32), .PRE_W(16)) dut (
    .clk_bus     (clk_bus),
    .rst         (rst),
    .bus_address (bus_address),
    .bus_data_i  (bus_data_i),
    .bus_read    (bus_read),
    .bus_write   (bus_write),
    .bus_data_o  (bus_data_o),
    .irq         (irq)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [15:0] m_pre, m_pc;
  logic [63:0] m_time;
  logic [31:0] m_shadow;
  logic        m_irq;
  logic        m_en [NCH];
  logic        m_per[NCH];
  logic        m_ie [NCH];
  logic        m_exp[NCH];
  logic [31:0] m_load [NCH];
  logic [31:0] m_count[NCH];

  task automatic m_reset();
    m_pre = '0; m_pc = '0; m_time = '0; m_shadow = '0; m_irq = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      m_en[i] = 1'b0; m_per[i] = 1'b0; m_ie[i] = 1'b0; m_exp[i] = 1'b0;
      m_load[i] = '0; m_count[i] = '0;
    end
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] a);
    int ch;
    ch = int'(a[7:4]) - 1;
    case (a & 8'hFC)
      8'h00:   return m_time[31:0];
      8'h04:   return m_shadow;
      8'h08:   return {16'h0, m_pre};
      default: ;
    endcase
    if (ch >= 0 && ch < NCH) begin
      case (a[3:2])
        2'd0:    return {29'h0, m_ie[ch], m_per[ch], m_en[ch]};
        2'd1:    return m_load[ch];
        2'd2:    return m_count[ch];
        default: return {31'h0, m_exp[ch]};
      endcase
    end
    return 32'h0;
  endfunction

  // one clock edge of the register-level behaviour
  task automatic m_step(input logic rd, input logic wr, input logic [7:0] a, input logic [31:0] d);
    logic tk, irq_n, hit, fire;
    tk    = (m_pc == m_pre);
    irq_n = 1'b0;
    for (int i = 0; i < NCH; i++) irq_n |= m_exp[i] & m_ie[i];
    if (rd && (a & 8'hFC) == 8'h00) m_shadow = m_time[63:32];
    if (tk) m_time = m_time + 64'd1;
    if (wr && (a & 8'hFC) == 8'h08) begin
      m_pre = d[15:0];
      m_pc  = '0;
    end else begin
      m_pc = tk ? 16'h0 : m_pc + 16'h1;
    end
    for (int i = 0; i < NCH; i++) begin
      hit  = wr && (a[7:4] == 4'(i + 1));
      fire = 1'b0;
      if (hit && a[3:2] == 2'd0) begin
        if (d[0] && !m_en[i]) m_count[i] = m_load[i];
        {m_ie[i], m_per[i], m_en[i]} = d[2:0];
      end else if (tk && m_en[i]) begin
        if (m_count[i] != 0) m_count[i] = m_count[i] - 1;
        else begin
          fire = 1'b1;
          if (m_per[i]) m_count[i] = m_load[i];
          else          m_en[i] = 1'b0;
        end
      end
      if (hit && a[3:2] == 2'd1) m_load[i] = d;
      if (hit && a[3:2] == 2'd3 && d[0]) m_exp[i] = 1'b0;
      if (fire) m_exp[i] = 1'b1;
    end
    m_irq = irq_n;
  endtask

  // one bus cycle, entered and left at a falling edge
  task automatic cyc(input logic rd, input logic wr, input logic [7:0] a, input logic [31:0] d,
                     output logic [31:0] q);
    bus_read = rd; bus_write = wr; bus_address = a; bus_data_i = d;
    #1;
    q = bus_data_o;
    if (rd) chk($sformatf("rd%02h", a), bus_data_o, m_read(a));
    else    chk("rd_idle", bus_data_o, 32'h0);
    chk("irq", irq, m_irq);
    @(posedge clk_bus);
    if (rst) m_reset();
    else     m_step(rd, wr, a, d);
    @(negedge clk_bus);
    bus_read = 1'b0; bus_write = 1'b0;
  endtask

  task automatic bwr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] unused_q;
    cyc(1'b0, 1'b1, a, d, unused_q);
  endtask

  task automatic brd(input logic [7:0] a, output logic [31:0] q);
    cyc(1'b1, 1'b0, a, 32'h0, q);
  endtask

  task automatic idle(input int n);
    logic [31:0] unused_q;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 32'h0, unused_q);
  endtask

  initial begin
    logic [31:0] q;
    logic [7:0]  ra;
    logic [31:0] rdat;
    logic        rr, rw;
    int          k;

    rst = 1'b1; bus_read = 1'b0; bus_write = 1'b0; bus_address = '0; bus_data_i = '0;
    m_reset();
    @(negedge clk_bus);

    // everything reads zero while reset is held
    for (int a = 0; a < 256; a += 4) begin
      brd(8'(a), q);
      chk("rst_rd", q, 32'h0);
    end
    chk("rst_irq", irq, 1'b0);
    idle(1);
    rst = 1'b0;

    // PRESCALE=3; the write edge itself still ticks under the reset PRESCALE of 0
    bwr(8'h08, 32'd3);
    for (int c = 1; c <= 40; c++) begin
      if (c == 33) begin
        brd(8'h00, q);
        chk("time_9", q, 32'd9);
      end else begin
        idle(1);
      end
    end
    brd(8'h00, q); chk("time_40", q, 32'd11);
    brd(8'h04, q); chk("time_hi0", q, 32'd0);

    // carry across the low word, read on a tick edge
    bwr(8'h08, 32'd1000);
    force dut.time_q = 64'h0000_0000_FFFF_FFFF;
    idle(1);
    release dut.time_q;
    m_time = 64'h0000_0000_FFFF_FFFF;
    bwr(8'h08, 32'd2);
    idle(2);
    brd(8'h00, q); chk("carry_lo", q, 32'hFFFF_FFFF);
    brd(8'h04, q); chk("carry_hi", q, 32'h0);
    brd(8'h00, q); chk("carry_lo2", q, 32'h0);
    brd(8'h04, q); chk("carry_hi2", q, 32'h1);

    // one-shot ch0: LOAD=5, expiry six ticks after enable
    bwr(8'h08, 32'd0);
    bwr(8'h14, 32'd5);
    bwr(8'h10, 32'd5);
    k = 0;
    for (int c = 1; c <= 20 && k == 0; c++) begin
      brd(8'h1C, q);
      if (q[0]) k = c;
    end
    chk("os_lat", k, 7);
    brd(8'h10, q); chk("os_ctrl", q, 32'h4);
    brd(8'h18, q); chk("os_count", q, 32'h0);
    chk("os_irq", irq, 1'b1);
    bwr(8'h1C, 32'd1); chk("w1c_irq_hold", irq, 1'b1);
    idle(1);           chk("w1c_irq_fall", irq, 1'b0);

    // periodic ch2: LOAD=2, expiries every third tick, W1C on an expiry edge loses
    bwr(8'h34, 32'd2);
    bwr(8'h30, 32'd7);
    idle(5);
    bwr(8'h3C, 32'd1);
    brd(8'h3C, q); chk("per_w1c_set", q, 32'd1);
    bwr(8'h3C, 32'd1);
    brd(8'h3C, q); chk("per_w1c_clr", q, 32'd0);
    bwr(8'h30, 32'd0);
    bwr(8'h3C, 32'd1);

    // ch1: disabling on the expiry edge suppresses EXPIRED
    bwr(8'h24, 32'd3);
    bwr(8'h20, 32'd1);
    idle(3);
    bwr(8'h20, 32'd0);
    brd(8'h2C, q); chk("dis_exp", q, 32'd0);
    brd(8'h28, q); chk("dis_count", q, 32'd0);
    brd(8'h20, q); chk("dis_ctrl", q, 32'd0);
    bwr(8'h20, 32'd1);
    idle(1);
    bwr(8'h20, 32'd0);
    brd(8'h28, q); chk("hold_count", q, 32'd2);

    // reset mid-count with ch3 (periodic, LOAD=0) holding irq high
    bwr(8'h24, 32'd100);
    bwr(8'h20, 32'd1);
    bwr(8'h40, 32'd7);
    idle(3);
    chk("pre_rst_irq", irq, 1'b1);
    brd(8'h28, q); chk("pre_rst_cnt", q, 32'd96);
    rst = 1'b1; bus_read = 1'b1; bus_address = 8'h28;
    #1 chk("rst_async_cnt", bus_data_o, 32'h0);
    chk("rst_async_irq", irq, 1'b0);
    bus_address = 8'h00;
    #1 chk("rst_async_time", bus_data_o, 32'h0);
    bus_read = 1'b0;
    m_reset();
    @(negedge clk_bus);
    idle(2);
    rst = 1'b0;

    // random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      ra   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8'h5F));
      rdat = $urandom_range(0, 7);
      if ($urandom_range(0, 7) == 0) rdat = rdat | 32'hA5A5_0000;
      rr   = 1'($urandom_range(0, 1));
      rw   = ($urandom_range(0, 2) == 0);
      cyc(rr, rw, ra, rdat, q);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
